mem_stage_ctrl: RTL and testbench

//  Memory-stage controller between the EX/MEM pipeline register and the MEM/WB register.

---
 rtl/mem_ctrl_defs.sv | 13 +
 rtl/dff.sv | 18 +
 rtl/mem_timeout_cnt.sv | 24 ++
 rtl/mem_stage_ctrl.sv | 123 ++++++++++++
 tb/tb_mem_stage_ctrl.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_ctrl_defs.sv
// Shared definitions for the memory-stage controller: FSM state encoding and default parameters.
package mem_ctrl_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int          TIMEOUT_DEF  = 255;
    localparam logic [15:0] ERR_DATA_DEF = 16'hDEAD;

endpackage

// File: rtl/dff.sv
// Generic register with asynchronous active-high reset to RST_VAL.
// Latency: 1 cycle; no backpressure.
module dff #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= RST_VAL;
        else     q <= d;
    end

endmodule

// File: rtl/mem_timeout_cnt.sv
// WAIT-cycle counter; tc flags the TIMEOUT-th enabled cycle combinationally.
// Latency: 0 cycles for tc; no backpressure.
module mem_timeout_cnt #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [15:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en)  cnt <= cnt + 16'd1;
    end

    // cnt counts completed WAIT cycles, so TIMEOUT-1 marks the last allowed one
    assign tc = en & (cnt == 16'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage_ctrl.sv
// EX/MEM -> data memory req/done handshake; min 3 cycles per access, 0 for non-memory ops.
// Holds mem_stall until done or timeout; MEM_ALIGN_CHK_EN rejects odd addresses.
module mem_stage_ctrl
    import mem_ctrl_defs::*;
#(
    parameter int          TIMEOUT  = TIMEOUT_DEF,
    parameter logic [15:0] ERR_DATA = ERR_DATA_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] EX_MEM_ex_res,
    input  logic [15:0] EX_MEM_wr_data,
    input  logic        EX_MEM_mem_rd,
    input  logic        EX_MEM_mem_wr,
    input  logic        EX_MEM_halt,
    input  logic        flush,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_done,
    output logic [15:0] data_out,
    output logic        mem_stall,
    output logic        err_timeout,
    output logic        err_align
);

    logic [1:0]  state_raw;
    state_t      state_q;
    state_t      state_nxt;
    logic [15:0] data_q;
    logic [15:0] data_nxt;
    logic        cancel_q;
    logic        cancel_nxt;

    logic op, misalign, issue, in_idle, in_wait;
    logic tc, done_ok, tmo, wait_end;

    assign state_q = state_t'(state_raw);
    assign in_idle = (state_q == ST_IDLE);
    assign in_wait = (state_q == ST_WAIT);

    // rst gating keeps the combinational request path quiet while reset is held
    assign op = (EX_MEM_mem_rd | EX_MEM_mem_wr) & ~EX_MEM_halt & ~flush & ~rst;

`ifdef MEM_ALIGN_CHK_EN
    assign misalign = op & EX_MEM_ex_res[0];
`else
    assign misalign = 1'b0;
`endif

    assign issue    = in_idle & op & ~misalign;
    assign done_ok  = in_wait & mem_done;
    assign tmo      = in_wait & tc & ~mem_done;
    assign wait_end = done_ok | tmo;

    mem_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo_cnt (
        .clk (clk),
        .rst (rst),
        .clr (~in_wait),
        .en  (in_wait),
        .tc  (tc)
    );

    always_comb begin
        state_nxt  = state_q;
        data_nxt   = data_q;
        cancel_nxt = cancel_q;
        case (state_q)
            ST_IDLE: begin
                data_nxt   = '0;
                cancel_nxt = 1'b0;
                if (issue) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (flush) cancel_nxt = 1'b1;
                if (wait_end) begin
                    // a squashed access still has to drain, but its result is dropped
                    if (cancel_q | flush) begin
                        state_nxt  = ST_IDLE;
                        cancel_nxt = 1'b0;
                    end else begin
                        state_nxt = ST_DONE;
                        if (done_ok) data_nxt = EX_MEM_mem_rd ? mem_rdata : 16'h0000;
                        else         data_nxt = ERR_DATA;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
                data_nxt  = '0;
            end
            default: begin
                state_nxt  = ST_IDLE;
                data_nxt   = '0;
                cancel_nxt = 1'b0;
            end
        endcase
    end

    dff #(.W(2), .RST_VAL(ST_IDLE)) u_state (
        .clk (clk), .rst (rst), .d (state_nxt), .q (state_raw)
    );

    dff #(.W(16), .RST_VAL(16'h0000)) u_data (
        .clk (clk), .rst (rst), .d (data_nxt), .q (data_q)
    );

    dff #(.W(1), .RST_VAL(1'b0)) u_cancel (
        .clk (clk), .rst (rst), .d (cancel_nxt), .q (cancel_q)
    );

    assign mem_req     = issue;
    assign mem_wr      = issue & EX_MEM_mem_wr;
    assign mem_addr    = issue ? EX_MEM_ex_res  : 16'h0000;
    assign mem_wdata   = issue ? EX_MEM_wr_data : 16'h0000;
    assign mem_stall   = issue | in_wait;
    assign err_timeout = tmo;
    assign err_align   = misalign & in_idle;
    assign data_out    = data_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl with TIMEOUT=4; each access is predicted from its latency alone.
module tb_mem_stage_ctrl;

    localparam int          TO   = 4;
    localparam logic [15:0] ERRV = 16'hDEAD;

    typedef logic [52:0] ovec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] EX_MEM_ex_res = '0;
    logic [15:0] EX_MEM_wr_data = '0;
    logic        EX_MEM_mem_rd = 1'b0;
    logic        EX_MEM_mem_wr = 1'b0;
    logic        EX_MEM_halt = 1'b0;
    logic        flush = 1'b0;
    logic        mem_req, mem_wr;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_done = 1'b0;
    logic [15:0] data_out;
    logic        mem_stall, err_timeout, err_align;

    int checks = 0;
    int errors = 0;

    mem_stage_ctrl #(.TIMEOUT(TO), .ERR_DATA(ERRV)) dut (
        .clk            (clk),
        .rst            (rst),
        .EX_MEM_ex_res  (EX_MEM_ex_res),
        .EX_MEM_wr_data (EX_MEM_wr_data),
        .EX_MEM_mem_rd  (EX_MEM_mem_rd),
        .EX_MEM_mem_wr  (EX_MEM_mem_wr),
        .EX_MEM_halt    (EX_MEM_halt),
        .flush          (flush),
        .mem_req        (mem_req),
        .mem_wr         (mem_wr),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_done       (mem_done),
        .data_out       (data_out),
        .mem_stall      (mem_stall),
        .err_timeout    (err_timeout),
        .err_align      (err_align)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic ovec_t obs();
        return {mem_req, mem_wr, mem_addr, mem_wdata, data_out, mem_stall, err_timeout, err_align};
    endfunction

    function automatic ovec_t ev(input logic req, input logic wr, input logic [15:0] a,
                                 input logic [15:0] wd, input logic [15:0] d, input logic stall,
                                 input logic tmo, input logic al);
        return {req, wr, a, wd, d, stall, tmo, al};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic hlt, input logic fl,
                         input logic [15:0] a, input logic [15:0] wd);
        EX_MEM_mem_rd  = rd;
        EX_MEM_mem_wr  = wr;
        EX_MEM_halt    = hlt;
        flush          = fl;
        EX_MEM_ex_res  = a;
        EX_MEM_wr_data = wd;
    endtask

    // One access from the IDLE issue cycle to the cycle after it retires.
    // lat = WAIT cycle carrying mem_done (0 = never); flush_at = WAIT cycle carrying flush (0 = none).
    task automatic run_access(input string tag, input logic rd, input logic wr,
                              input logic [15:0] a, input logic [15:0] wd, input logic [15:0] rv,
                              input int lat, input int flush_at);
        ovec_t       e;
        logic [15:0] exp_d;
        bit          cancelled = 0;
        drive(rd, wr, 1'b0, 1'b0, a, wd);
        mem_done = 1'b0;
        #1;
        e = ev(1'b1, wr, a, wd, 16'h0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL %s issue: outputs %h, expected %h", tag, obs(), e);
        end
        tick();
        for (int w = 1; w <= TO; w++) begin
            if (w == flush_at) begin
                drive(1'b0, 1'b0, 1'b0, 1'b1, a, wd);
                cancelled = 1;
            end
            mem_done  = (w == lat);
            mem_rdata = rv;
            #1;
            e = ev(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b1, (w == TO) && (w != lat), 1'b0);
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL %s wait%0d: outputs %h, expected %h", tag, w, obs(), e);
            end
            tick();
            mem_done = 1'b0;
            flush    = 1'b0;
            if (w == lat || w == TO) break;
        end
        if (cancelled) begin
            #1;
            e = ev(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL %s cancel_idle: outputs %h, expected %h", tag, obs(), e);
            end
            tick();
        end else begin
            exp_d = (lat >= 1 && lat <= TO) ? (rd ? rv : 16'h0) : ERRV;
            #1;
            e = ev(1'b0, 1'b0, 16'h0, 16'h0, exp_d, 1'b0, 1'b0, 1'b0);
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL %s done: outputs %h, expected %h", tag, obs(), e);
            end
            tick();
        end
    endtask

    task automatic idle_cycle(input string tag, input logic rd, input logic wr, input logic hlt,
                              input logic fl, input logic [15:0] a, input logic dn);
        ovec_t e;
        drive(rd, wr, hlt, fl, a, 16'h5A5A);
        mem_done  = dn;
        mem_rdata = 16'hFFFF;
        #1;
        e = ev(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL %s: outputs %h, expected %h", tag, obs(), e);
        end
        tick();
        mem_done = 1'b0;
    endtask

    task automatic test_reset();
        ovec_t e;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0040, 16'h0);
        #3;
        e = '0;
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL reset_held: outputs %h, expected %h", obs(), e);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        #1;
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL reset_release: outputs %h, expected %h", obs(), e);
        end
        tick();
    endtask

    task automatic test_load();
        run_access("load", 1'b1, 1'b0, 16'h0040, 16'h0, 16'h1234, 2, 0);
        idle_cycle("load_after", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic test_store();
        run_access("store", 1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h7777, 1, 0);
        idle_cycle("store_after", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic test_timeout();
        run_access("timeout", 1'b1, 1'b0, 16'h0080, 16'h0, 16'h4321, 0, 0);
        idle_cycle("timeout_after", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        run_access("done_at_limit", 1'b1, 1'b0, 16'h0082, 16'h0, 16'h9876, TO, 0);
        idle_cycle("limit_after", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic test_flush();
        run_access("flush_wait", 1'b1, 1'b0, 16'h0020, 16'h0, 16'hAAAA, 3, 1);
        run_access("flush_on_done", 1'b1, 1'b0, 16'h0022, 16'h0, 16'hBBBB, 2, 2);
        idle_cycle("flush_idle", 1'b1, 1'b0, 1'b0, 1'b1, 16'h0024, 1'b0);
    endtask

    task automatic test_reset_mid_wait();
        ovec_t e;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0030, 16'h0);
        tick();
        rst = 1'b1;
        #1;
        e = '0;
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL rst_mid_wait: outputs %h, expected %h", obs(), e);
        end
        tick();
        rst = 1'b0;
        idle_cycle("late_done", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        idle_cycle("no_done_after_rst", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic test_halt_nonmem();
        idle_cycle("halt_load", 1'b1, 1'b0, 1'b1, 1'b0, 16'h0050, 1'b0);
        idle_cycle("halt_store", 1'b0, 1'b1, 1'b1, 1'b0, 16'h0052, 1'b0);
        idle_cycle("nonmem_done_ignored", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0054, 1'b1);
    endtask

    task automatic test_align();
`ifdef MEM_ALIGN_CHK_EN
        ovec_t e;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0041, 16'h0);
        #1;
        e = ev(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL align_reject: outputs %h, expected %h", obs(), e);
        end
        tick();
        idle_cycle("align_after", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
`else
        run_access("odd_addr", 1'b1, 1'b0, 16'h0041, 16'h0, 16'h5555, 1, 0);
        idle_cycle("odd_after", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
`endif
    endtask

    task automatic test_back_to_back();
        run_access("b2b_a", 1'b1, 1'b0, 16'h0100, 16'h0, 16'h1111, 1, 0);
        run_access("b2b_b", 1'b0, 1'b1, 16'h0102, 16'hCAFE, 16'h2222, 3, 0);
        run_access("b2b_c", 1'b1, 1'b0, 16'h0104, 16'h0, 16'h3333, 2, 0);
        idle_cycle("b2b_after", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic test_random();
        int          kind;
        int          lat;
        int          fat;
        logic [15:0] a;
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 3);
            a    = 16'($urandom);
            if (kind <= 1) begin
                lat = $urandom_range(0, 6);
                fat = ($urandom_range(0, 4) == 0) ? $urandom_range(1, TO) : 0;
                run_access("rand_acc", kind == 0, kind == 1, a & 16'hFFFE, 16'($urandom),
                           16'($urandom), lat, fat);
            end else if (kind == 2) begin
                idle_cycle("rand_nonmem", 1'b0, 1'b0, 1'($urandom), 1'b0, a, 1'($urandom));
            end else begin
                idle_cycle("rand_squashed", 1'($urandom), 1'b1, 1'b1, 1'($urandom), a, 1'($urandom));
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_timeout();
        test_flush();
        test_reset_mid_wait();
        test_halt_nonmem();
        test_align();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
